// File: rtl/tone_period_meter_pkg.sv
// Shared types and defaults for the tone period meter. The period range tracks the
// note divider's 16-bit divide range so divide values and measured periods line up.
package tone_period_meter_pkg;

  localparam int unsigned NoteDivBits    = 16;
  localparam int unsigned DefMaxPeriod   = 1 << NoteDivBits;
  localparam int unsigned DefMinPeriod   = 16;
  localparam int unsigned DefSyncStages  = 2;

  typedef enum logic {
    StIdle,
    StMeasure
  } state_e;

  // Counter width able to hold max_period itself.
  function automatic int unsigned cnt_width(input int unsigned max_period);
    return $unsigned($clog2(max_period + 1));
  endfunction

endpackage

// File: rtl/tone_period_meter_if.sv
// Tone input and measurement results of the tone period meter.
// The meter uses the slave modport; whoever drives the tone and reads results uses master.
interface tone_period_meter_if #(
    parameter int unsigned W = 17
) ();

    logic         tone_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         period_valid;
    logic         silent;

    modport master (
        output tone_in,
        input  period,
        input  high_time,
        input  period_valid,
        input  silent
    );

    modport slave (
        input  tone_in,
        output period,
        output high_time,
        output period_valid,
        output silent
    );

endinterface

// File: rtl/tone_period_meter_sync_edge_detect.sv
// Synchronizes the asynchronous tone and flags its rising/falling edges,
// SYNC_STAGES+1 cycles after the input transition.
module tone_period_meter_sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= w_sync;
        end
    end

    assign o_rise = w_sync & ~r_hist;
    assign o_fall = ~w_sync & r_hist;

endmodule

// File: rtl/tone_period_meter.sv
// Measures tone period and high time in clk cycles between accepted rising edges;
// edges closer than MIN_PERIOD are treated as bounce, silence beyond MAX_PERIOD times out.
module tone_period_meter
    import tone_period_meter_pkg::*;
#(
    parameter int unsigned MAX_PERIOD  = DefMaxPeriod,
    parameter int unsigned MIN_PERIOD  = DefMinPeriod,
    parameter int unsigned SYNC_STAGES = DefSyncStages
) (
    input  logic                clk,
    input  logic                rst,
    tone_period_meter_if.slave  bus
);

    localparam int unsigned W      = cnt_width(MAX_PERIOD);
    localparam logic [W-1:0] CntMax = W'(MAX_PERIOD);
    localparam logic [W-1:0] CntMin = W'(MIN_PERIOD);
    localparam logic [W-1:0] CntOne = W'(1);

    logic         w_rise;
    logic         w_fall;
    logic         w_accept;
    logic         w_at_max;

    state_e       r_state;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_hi_cap;
    logic         r_hi_seen;
    logic [W-1:0] r_period;
    logic [W-1:0] r_high_time;
    logic         r_period_valid;
    logic         r_silent;

    tone_period_meter_sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.tone_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_accept = w_rise && (r_cnt >= CntMin);
    assign w_at_max = (r_cnt == CntMax);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= StIdle;
            r_cnt          <= '0;
            r_hi_cap       <= '0;
            r_hi_seen      <= 1'b0;
            r_period       <= '0;
            r_high_time    <= '0;
            r_period_valid <= 1'b0;
            r_silent       <= 1'b1;
        end else begin
            r_period_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    // First rise only opens a measurement window; it has nothing to report.
                    if (w_rise) begin
                        r_state   <= StMeasure;
                        r_cnt     <= CntOne;
                        r_hi_cap  <= '0;
                        r_hi_seen <= 1'b0;
                    end
                end
                StMeasure: begin
                    if (w_accept) begin
                        r_period       <= r_cnt;
                        r_high_time    <= r_hi_cap;
                        r_period_valid <= 1'b1;
                        r_silent       <= 1'b0;
                        r_cnt          <= CntOne;
                        r_hi_cap       <= '0;
                        r_hi_seen      <= 1'b0;
                    end else if (w_at_max) begin
                        r_state     <= StIdle;
                        r_cnt       <= '0;
                        r_period    <= '0;
                        r_high_time <= '0;
                        r_silent    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CntOne;
                        if (w_fall && (r_cnt >= CntMin) && !r_hi_seen) begin
                            r_hi_cap  <= r_cnt;
                            r_hi_seen <= 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.period       = r_period;
    assign bus.high_time    = r_high_time;
    assign bus.period_valid = r_period_valid;
    assign bus.silent       = r_silent;

endmodule

// File: tb/tb_tone_period_meter.sv
// Bench for tone_period_meter: directed tone scenarios plus random tones, checked every cycle
// against a timestamp-based model of the measurement rules.
module tb_tone_period_meter;

    localparam int unsigned TbMax  = 4096;
    localparam int unsigned TbMin  = 16;
    localparam int unsigned TbSync = 2;
    localparam int unsigned TbW    = $clog2(TbMax + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    tone_period_meter_if #(.W(TbW)) bus ();

    tone_period_meter #(
        .MAX_PERIOD  (TbMax),
        .MIN_PERIOD  (TbMin),
        .SYNC_STAGES (TbSync)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks     = 0;
    int errors     = 0;
    int valid_seen = 0;

    // Model: tone samples seen by the synchronizer, plus the cycle of the last accepted rise.
    bit     samp [TbSync+1];
    bit     m_meas;
    bit     m_hi_seen;
    longint m_now;
    longint m_t0;
    longint m_hi_cap;
    longint exp_period;
    longint exp_high;
    bit     exp_valid;
    bit     exp_silent;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (samp[i]) samp[i] = 1'b0;
        m_meas     = 1'b0;
        m_hi_seen  = 1'b0;
        m_t0       = 0;
        m_hi_cap   = 0;
        exp_period = 0;
        exp_high   = 0;
        exp_valid  = 1'b0;
        exp_silent = 1'b1;
    endtask

    task automatic model_edge(input bit t);
        bit     rise;
        bit     fall;
        longint el;
        rise = samp[TbSync-1] && !samp[TbSync];
        fall = !samp[TbSync-1] && samp[TbSync];
        for (int i = TbSync; i > 0; i--) samp[i] = samp[i-1];
        samp[0]   = t;
        m_now++;
        el        = m_now - m_t0;
        exp_valid = 1'b0;
        if (!m_meas) begin
            if (rise) begin
                m_meas    = 1'b1;
                m_t0      = m_now;
                m_hi_cap  = 0;
                m_hi_seen = 1'b0;
            end
        end else if (rise && el >= TbMin) begin
            exp_valid  = 1'b1;
            exp_period = el;
            exp_high   = m_hi_cap;
            exp_silent = 1'b0;
            m_t0       = m_now;
            m_hi_cap   = 0;
            m_hi_seen  = 1'b0;
        end else if (el == TbMax) begin
            m_meas     = 1'b0;
            exp_period = 0;
            exp_high   = 0;
            exp_silent = 1'b1;
        end else if (fall && el >= TbMin && !m_hi_seen) begin
            m_hi_cap  = el;
            m_hi_seen = 1'b1;
        end
    endtask

    task automatic compare();
        check("period_valid", bus.period_valid, exp_valid);
        check("silent", bus.silent, exp_silent);
        check("period", bus.period, exp_period);
        check("high_time", bus.high_time, exp_high);
        if (bus.period_valid) valid_seen++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else     model_edge(bus.tone_in);
        compare();
    endtask

    task automatic run_tone(input int unsigned per, input int unsigned hi, input bit bounce,
                            input int unsigned nper);
        int unsigned ph;
        for (int unsigned i = 0; i < per * nper; i++) begin
            ph = i % per;
            bus.tone_in = (ph < hi) && !(bounce && ph >= 2 && ph < 5);
            tick();
        end
    endtask

    task automatic run_quiet(input int unsigned n);
        bus.tone_in = 1'b0;
        repeat (n) tick();
    endtask

    // Asserts reset between clock edges and checks the outputs clear before the next edge.
    task automatic async_reset(input int unsigned hold);
        #3 rst = 1'b1;
        #1;
        model_reset();
        compare();
        repeat (hold) tick();
        rst = 1'b0;
    endtask

    initial begin
        int unsigned per;
        int unsigned hi;
        bus.tone_in = 1'b0;
        model_reset();
        m_now = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        valid_seen = 0;
        run_tone(1000, 400, 1'b0, 6);
        check("n_valid_1000", valid_seen, 5);
        check("dir_period_1000", bus.period, 1000);
        check("dir_high_400", bus.high_time, 400);
        check("dir_silent_tone", bus.silent, 0);

        valid_seen = 0;
        run_tone(1000, 400, 1'b1, 4);
        check("n_valid_bounce", valid_seen, 4);
        check("dir_period_bounce", bus.period, 1000);
        check("dir_high_bounce", bus.high_time, 400);

        run_tone(2727, 1300, 1'b0, 3);
        run_tone(2293, 1100, 1'b0, 3);
        check("dir_period_switch", bus.period, 2293);
        check("dir_high_switch", bus.high_time, 1100);

        run_quiet(5000);
        check("dir_timeout_silent", bus.silent, 1);
        check("dir_timeout_period", bus.period, 0);

        valid_seen = 0;
        run_tone(TbMax, 2000, 1'b0, 3);
        check("n_valid_max", valid_seen, 2);
        check("dir_period_max", bus.period, TbMax);
        check("dir_silent_max", bus.silent, 0);

        run_tone(1000, 400, 1'b0, 1);
        run_tone(1000, 400, 1'b0, 1) ;
        async_reset(3);
        valid_seen = 0;
        run_tone(1000, 400, 1'b0, 3);
        check("n_valid_after_rst", valid_seen, 2);
        check("dir_period_after_rst", bus.period, 1000);

        for (int n = 0; n < 6; n++) begin
            per = $urandom_range(1500, 20);
            hi  = $urandom_range(per - 1, 1);
            run_tone(per, hi, 1'($urandom_range(1, 0)), $urandom_range(2, 1));
            if ($urandom_range(3, 0) == 0) run_quiet($urandom_range(4500, 10));
        end
        run_quiet(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
